// File: rtl/pipeline_debug_ctrl.sv
// Debug controller for the 5-stage pipeline: byte commands from a UART RX drive
// pc_enable/pc_reset, and a 24-byte snapshot frame is streamed to a UART TX.
module pipeline_debug_ctrl #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int unsigned           RESET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  pc_enable,
    output logic                  pc_reset,
    input  logic [DATA_WIDTH-1:0] pc_addr_in,
    input  logic [DATA_WIDTH-1:0] pc_instr_in,
    input  logic [DATA_WIDTH-1:0] reg_w_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rs_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rt_data_in,
    output logic                  busy
);

    localparam int unsigned FRAME_WORDS = 6;
    localparam int unsigned FRAME_W     = FRAME_WORDS * DATA_WIDTH;
    localparam int unsigned FRAME_BYTES = FRAME_W / 8;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned RST_W       = 4;

    localparam logic [7:0] CMD_RESET = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_RUN   = 8'h43;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_STEP,
        ST_RUN,
        ST_SNAP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    state_t                  state_q;
    logic [RST_W-1:0]        rst_cnt_q;
    logic [DATA_WIDTH-1:0]   cycle_cnt_q;
    logic [IDX_W-1:0]        byte_idx_q;
    logic [FRAME_W-1:0]      frame_q;

    logic halt_c;
    logic pause_c;

    // Pipeline controls are decoded from state; RUN gates on the live fetch word
    // so the halt instruction never advances past fetch.
    always_comb begin
        halt_c    = (pc_instr_in == HALT_INSTR);
        pause_c   = rx_valid && (rx_data == CMD_PAUSE);
        pc_enable = 1'b0;
        pc_reset  = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_RESET: pc_reset  = 1'b1;
            ST_STEP:  pc_enable = 1'b1;
            ST_RUN:   pc_enable = !halt_c && !pause_c;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            byte_idx_q  <= '0;
            frame_q     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
        end else begin
            tx_start <= 1'b0;
            if (pc_enable) begin
                cycle_cnt_q <= cycle_cnt_q + DATA_WIDTH'(1);
            end

            case (state_q)
                ST_RESET: begin
                    cycle_cnt_q <= '0;
                    if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                        rst_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RESET: state_q <= ST_RESET;
                            CMD_STEP:  state_q <= ST_STEP;
                            CMD_RUN:   state_q <= ST_RUN;
                            CMD_DUMP:  state_q <= ST_SNAP;
                            default:   ;
                        endcase
                    end
                end

                ST_STEP: state_q <= ST_SNAP;

                ST_RUN: begin
                    if (halt_c || pause_c) begin
                        state_q <= ST_SNAP;
                    end
                end

                ST_SNAP: begin
                    frame_q    <= {cycle_cnt_q, pc_addr_in, pc_instr_in,
                                   reg_w_data_in, reg_rs_data_in, reg_rt_data_in};
                    byte_idx_q <= '0;
                    state_q    <= ST_SEND;
                end

                // Frame is shifted out MSB first; the top byte is always next.
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= frame_q[FRAME_W-1 -: 8];
                        state_q  <= ST_WAIT_TX;
                    end
                end

                // tx_start is high only in the first WAIT_TX cycle, before busy rises.
                ST_WAIT_TX: begin
                    if (!tx_start && !tx_busy) begin
                        if (byte_idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                            frame_q    <= {frame_q[FRAME_W-9:0], 8'h00};
                            state_q    <= ST_SEND;
                        end
                    end
                end

                default: state_q <= ST_RESET;
            endcase
        end
    end

endmodule
